// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 do/redo loop sequencer: sizes, state
// encoding and the field layout of the decoder's do_data word.
package jtdsp16_pkg;

  localparam int DEPTH = 15;  // cache entries, i.e. the largest loop body
  localparam int AW    = 4;   // cache address width
  localparam int KW    = 7;   // loop-count width

  localparam int N_MSB = 10;
  localparam int N_LSB = 7;
  localparam int K_MSB = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2
  } state_t;

endpackage

// File: rtl/jtdsp16_do_mem.sv
// Loop-body instruction cache: 15x16 register file, one cen-gated write port
// and one asynchronous read port so a replayed word is ready in the fetch cycle.
module jtdsp16_do_mem
  import jtdsp16_pkg::*;
(
  input  logic          clk,
  input  logic          cen,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // NOTE: the array has no reset; every slot is written in FILL before any
  // REPLAY can read it, so a reset would only add flops for nothing.
  always_ff @(posedge clk) begin
    if (cen && we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jtdsp16_do_seq.sv
// DSP16 "do K { N words }" / "redo K" sequencer: captures the body on the first
// pass, replays it from the cache afterwards. Optional redo: JTDSP16_DO_REDO_EN.
module jtdsp16_do_seq
  import jtdsp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        do_start,
  input  logic [10:0] do_data,
  input  logic        fetch,
  input  logic [15:0] rom_dout,
  output logic        cache_sel,
  output logic [15:0] cache_dout,
  output logic        pc_hold,
  output logic        no_int,
  output logic        busy,
  output logic        loop_done,
  output logic        err
);

  state_t        state, state_nxt;
  logic [AW-1:0] n_r, n_nxt;
  logic [AW-1:0] wr_ptr, wr_nxt;
  logic [AW-1:0] rd_ptr, rd_nxt;
  logic [KW-1:0] iter, iter_nxt;
  logic          done_nxt, err_nxt, mem_we;
  logic [AW-1:0] req_n, last_slot;
  logic [KW-1:0] req_k, req_iter;
  logic [15:0]   mem_rdata;
`ifdef JTDSP16_DO_REDO_EN
  logic [AW-1:0] last_n, last_nxt;
`endif

  assign req_n     = do_data[N_MSB:N_LSB];
  assign req_k     = do_data[K_MSB:0];
  assign req_iter  = (req_k == '0) ? KW'(1) : req_k;  // K=0 still runs once
  assign last_slot = n_r - AW'(1);

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    n_nxt     = n_r;
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    iter_nxt  = iter;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    mem_we    = 1'b0;
`ifdef JTDSP16_DO_REDO_EN
    last_nxt  = last_n;
`endif
    case (state)
      IDLE: begin
        if (do_start) begin
          if (req_n != '0) begin
            n_nxt     = req_n;
            iter_nxt  = req_iter;
            wr_nxt    = '0;
            err_nxt   = (req_k == '0);
            state_nxt = FILL;
`ifdef JTDSP16_DO_REDO_EN
            last_nxt  = req_n;
`endif
          end else begin
`ifdef JTDSP16_DO_REDO_EN
            // redo: the cache still holds the previous body, skip the fill
            if (last_n != '0) begin
              n_nxt     = last_n;
              iter_nxt  = req_iter;
              rd_nxt    = '0;
              err_nxt   = (req_k == '0);
              state_nxt = REPLAY;
            end else begin
              err_nxt = 1'b1;
            end
`else
            err_nxt = 1'b1;
`endif
          end
        end
      end
      FILL: begin
        err_nxt = do_start;  // nesting is not supported
        if (fetch) begin
          mem_we = 1'b1;
          wr_nxt = wr_ptr + AW'(1);
          if (wr_ptr == last_slot) begin
            if (iter == KW'(1)) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              iter_nxt  = iter - KW'(1);
              rd_nxt    = '0;
              state_nxt = REPLAY;
            end
          end
        end
      end
      REPLAY: begin
        err_nxt = do_start;
        if (fetch) begin
          if (rd_ptr == last_slot) begin
            rd_nxt = '0;
            if (iter == KW'(1)) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              iter_nxt = iter - KW'(1);
            end
          end else begin
            rd_nxt = rd_ptr + AW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_r       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      iter      <= '0;
      loop_done <= 1'b0;
      err       <= 1'b0;
`ifdef JTDSP16_DO_REDO_EN
      last_n    <= '0;
`endif
    end else if (cen) begin
      state     <= state_nxt;
      n_r       <= n_nxt;
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      iter      <= iter_nxt;
      loop_done <= done_nxt;
      err       <= err_nxt;
`ifdef JTDSP16_DO_REDO_EN
      last_n    <= last_nxt;
`endif
    end
  end

  jtdsp16_do_mem u_mem (
    .clk   (clk),
    .cen   (cen),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (rom_dout),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Source select and PC hold drop with the same edge that returns to IDLE,
  // so the next fetch reads the ROM word after the body.
  assign cache_sel  = (state == REPLAY);
  assign pc_hold    = (state == REPLAY);
  assign busy       = (state != IDLE);
  assign no_int     = busy;
  assign cache_dout = cache_sel ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_jtdsp16_do_seq.sv
// Self-checking bench for jtdsp16_do_seq: a ROM model with its own PC feeds the
// DUT and a scoreboard of expected body words is checked at every fetch.
module tb_jtdsp16_do_seq;

  logic        clk = 1'b0;
  logic        rst_n, cen, do_start, fetch;
  logic [10:0] do_data;
  logic [15:0] rom_dout;
  logic        cache_sel, pc_hold, no_int, busy, loop_done, err;
  logic [15:0] cache_dout;

  typedef struct {
    logic [15:0] word;
    logic        from_cache;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rom [256];
  int          pc;
  int          checks, errors;
  int          delivered, done_cnt, err_cnt, exp_err;
  int          last_base, last_n_m;

  jtdsp16_do_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .do_start   (do_start),
    .do_data    (do_data),
    .fetch      (fetch),
    .rom_dout   (rom_dout),
    .cache_sel  (cache_sel),
    .cache_dout (cache_dout),
    .pc_hold    (pc_hold),
    .no_int     (no_int),
    .busy       (busy),
    .loop_done  (loop_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1ns later, model the ROM PC.
  task automatic tick(input logic c, input logic f, input logic ds, input logic [10:0] dd);
    exp_t        e;
    logic [15:0] word;
    logic        model_busy;
    @(negedge clk);
    cen = c; fetch = f; do_start = ds; do_data = dd;
    rom_dout = rom[pc[7:0]];
    #1;
    model_busy = (exp_q.size() != 0);
    check("busy", busy, model_busy);
    check("no_int", no_int, model_busy);
    if (c && loop_done) done_cnt++;
    if (c && err) err_cnt++;
    if (c && f && model_busy) begin
      e    = exp_q.pop_front();
      word = cache_sel ? cache_dout : rom_dout;
      check("word", word, e.word);
      check("cache_sel", cache_sel, e.from_cache);
      check("pc_hold", pc_hold, e.from_cache);
      delivered++;
    end else if (!model_busy) begin
      check("idle_cache_sel", cache_sel, 1'b0);
      check("idle_pc_hold", pc_hold, 1'b0);
    end
    if (c && f && !pc_hold) pc++;
  endtask

  task automatic clear_counts();
    done_cnt = 0; err_cnt = 0; exp_err = 0;
  endtask

  task automatic start_do(input int n, input int k);
    exp_t e;
    int   passes;
    passes = (k == 0) ? 1 : k;
    tick(1'b1, 1'b0, 1'b1, {n[3:0], k[6:0]});
    last_base = pc;
    last_n_m  = n;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < n; i++) begin
        e.word       = rom[(pc + i) % 256];
        e.from_cache = (p != 0);
        exp_q.push_back(e);
      end
    if (k == 0) exp_err++;
  endtask

  task automatic start_redo(input int k);
    exp_t e;
    int   passes;
    passes = (k == 0) ? 1 : k;
    tick(1'b1, 1'b0, 1'b1, {4'd0, k[6:0]});
`ifdef JTDSP16_DO_REDO_EN
    if (last_n_m != 0) begin
      for (int p = 0; p < passes; p++)
        for (int i = 0; i < last_n_m; i++) begin
          e.word       = rom[(last_base + i) % 256];
          e.from_cache = 1'b1;
          exp_q.push_back(e);
        end
      if (k == 0) exp_err++;
    end else begin
      exp_err++;
    end
`else
    passes = 0;
    exp_err++;
`endif
  endtask

  // Drain the scoreboard (or stop after stop_at words); optional do_start
  // injected on the cycle that consumes word number inj.
  task automatic run(input int stall, input int inj, input int stop_at);
    int   cyc, got0;
    logic c, f, ds;
    cyc  = 0;
    got0 = delivered;
    while (exp_q.size() != 0 && (delivered - got0) < stop_at && cyc < 20000) begin
      c  = (stall == 0) || ($urandom_range(99) >= stall);
      f  = (stall == 0) || ($urandom_range(99) >= stall);
      ds = ((delivered - got0) == inj);
      if (ds) exp_err++;
      tick(c, f, ds, 11'h4C9);
      cyc++;
    end
    check("cycle_budget", (cyc < 20000), 1'b1);
    if (exp_q.size() == 0) tick(1'b1, 1'b0, 1'b0, 11'h000);
  endtask

  initial begin
    int base;
    checks = 0; errors = 0; delivered = 0; pc = 0;
    last_base = 0; last_n_m = 0;
    for (int i = 0; i < 256; i++) rom[i] = {i[7:0] ^ 8'h5A, i[7:0]};
    rst_n = 1'b0; cen = 1'b0; fetch = 1'b0; do_start = 1'b0;
    do_data = '0; rom_dout = '0;
    clear_counts();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_no_int", no_int, 1'b0);
    check("rst_cache_sel", cache_sel, 1'b0);
    check("rst_pc_hold", pc_hold, 1'b0);
    check("rst_loop_done", loop_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_cache_dout", cache_dout, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 11'h000);

    // do N=3, K=4: 3 ROM words then 9 cached, PC held during replay
    clear_counts(); base = pc;
    start_do(3, 4);
    run(0, -1, 1000);
    check("d34_done", done_cnt, 1);
    check("d34_err", err_cnt, exp_err);
    check("d34_pc", pc, base + 3);

    // do N=2, K=1: fill only
    clear_counts(); base = pc;
    start_do(2, 1);
    run(0, -1, 1000);
    check("d21_done", done_cnt, 1);
    check("d21_err", err_cnt, exp_err);
    check("d21_pc", pc, base + 2);

    // do N=15, K=127 with random cen and fetch stalls
    clear_counts(); base = pc;
    start_do(15, 127);
    run(25, -1, 100000);
    check("d15_done", done_cnt, 1);
    check("d15_err", err_cnt, exp_err);
    check("d15_pc", pc, base + 15);

    // do_start during REPLAY: err pulse, loop unaffected
    clear_counts(); base = pc;
    start_do(4, 3);
    run(0, 6, 1000);
    check("nest_done", done_cnt, 1);
    check("nest_err", err_cnt, exp_err);
    check("nest_pc", pc, base + 4);

    // K=0: err pulse, body runs once
    clear_counts(); base = pc;
    start_do(2, 0);
    run(0, -1, 1000);
    check("k0_done", done_cnt, 1);
    check("k0_err", err_cnt, exp_err);
    check("k0_pc", pc, base + 2);

    // do N=4, K=2 then redo K=3 (err and IDLE when redo is disabled)
    clear_counts();
    start_do(4, 2);
    run(0, -1, 1000);
    base = pc;
    start_redo(3);
    run(0, -1, 1000);
    check("redo_err", err_cnt, exp_err);
    check("redo_pc", pc, base);
`ifdef JTDSP16_DO_REDO_EN
    check("redo_done", done_cnt, 2);
`else
    check("redo_done", done_cnt, 1);
`endif

    // Reset at the 5th replay word, then redo K=2 is illegal
    clear_counts();
    start_do(3, 4);
    run(0, -1, 7);
    @(negedge clk);
    rst_n = 1'b0; fetch = 1'b0; do_start = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_no_int", no_int, 1'b0);
    check("mid_rst_cache_sel", cache_sel, 1'b0);
    check("mid_rst_pc_hold", pc_hold, 1'b0);
    check("mid_rst_cache_dout", cache_dout, 16'h0000);
    check("mid_rst_loop_done", loop_done, 1'b0);
    exp_q.delete();
    last_n_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    start_redo(2);
    run(0, -1, 1000);
    check("post_rst_redo_err", err_cnt, 1);
    check("post_rst_redo_done", done_cnt, 0);
    check("post_rst_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
